// File: rtl/segment_scanner.sv
// segment_scanner: time-multiplexed driver for a bank of 7-segment digits.
// A slot counter divides time into per-digit slots; within each slot the
// selected digit is lit for a brightness-controlled window. New display
// content is double-buffered and only swapped in at the end of a full scan,
// so a frame never shows a mix of old and new digits.
module segment_scanner #(
  parameter int DIGITS         = 8,
  parameter int PERIOD         = 1024,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_blank,
  input  logic [3:0]            brightness,
  input  logic                  load,
  output logic [7:0]            segment,
  output logic [DIGITS-1:0]     select,
  output logic                  frame_done
);

  localparam int CW   = $clog2(PERIOD);
  localparam int IW   = $clog2(DIGITS);
  localparam int STEP = PERIOD / 16;

  localparam logic [CW-1:0]     CNT_LAST = CW'(PERIOD - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [7:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Scan position
  logic [CW-1:0] counter;
  logic [IW-1:0] index;
  logic          slot_end;
  logic          frame_end;

  // Double-buffered display content
  logic [4*DIGITS-1:0] act_data,  pend_data;
  logic [DIGITS-1:0]   act_dp,    pend_dp;
  logic [DIGITS-1:0]   act_blank, pend_blank;
  logic                act_lz,    pend_lz;
  logic                pending;

  // Brightness captured at the start of each slot
  logic [3:0]    bright_q;
  logic [CW:0]   thresh;
  logic          lit_window;

  // Per-cycle decode of the current digit
  logic [DIGITS-1:0] lz_mask;
  logic [3:0]        cur_nib;
  logic              dark;
  logic [7:0]        seg_lit;
  logic [DIGITS-1:0] sel_lit;

  assign slot_end   = (counter == CNT_LAST);
  assign frame_end  = slot_end && (index == IDX_LAST);
  assign frame_done = frame_end;

  // Hex nibble to lit segments, bit order gfedcba
  function automatic logic [6:0] hex7(input logic [3:0] v);
    hex7 = 7'h00;
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  // Slot counter and digit index; brightness latched at the top of each slot
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, as real flops do.
    if (rst) begin
      counter  <= '0;
      index    <= '0;
      bright_q <= '0;
    end else begin
      if (counter == '0) bright_q <= brightness;
      if (slot_end) begin
        counter <= '0;
        index   <= (index == IDX_LAST) ? '0 : index + 1'b1;
      end else begin
        counter <= counter + 1'b1;
      end
    end
  end

  // Pending/active buffers: loads park in pending, swap in at frame end
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '0;
      act_lz     <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_lz    <= 1'b0;
      pending    <= 1'b0;
    end else if (frame_end) begin
      // A load landing exactly on the frame boundary bypasses the buffer.
      if (load) begin
        act_data  <= data;
        act_dp    <= dp;
        act_blank <= blank;
        act_lz    <= lz_blank;
      end else if (pending) begin
        act_data  <= pend_data;
        act_dp    <= pend_dp;
        act_blank <= pend_blank;
        act_lz    <= pend_lz;
      end
      pending <= 1'b0;
    end else if (load) begin
      pend_data  <= data;
      pend_dp    <= dp;
      pend_blank <= blank;
      pend_lz    <= lz_blank;
      pending    <= 1'b1;
    end
  end

  // Leading-zero run from the most significant digit down to digit 1
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch or
    // loop, so no path can leave it unassigned and infer a latch.
    logic run;
    lz_mask = '0;
    run     = act_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      run        = run & (act_data[4*i +: 4] == 4'h0) & ~act_dp[i];
      lz_mask[i] = run;
    end
  end

  // On-window length scales with brightness; counter 0 is always inside it
  always_comb begin
    thresh     = (CW+1)'(({1'b0, bright_q} + 5'd1) * STEP);
    lit_window = ({1'b0, counter} < thresh);
  end

  // Decode the current digit into active-high segment and select patterns
  always_comb begin
    cur_nib = act_data[4*index +: 4];
    dark    = act_blank[index] | lz_mask[index] | ~lit_window;
    seg_lit = 8'h00;
    sel_lit = '0;
    if (!dark) begin
      seg_lit = {act_dp[index], hex7(cur_nib)};
      sel_lit = DIGITS'(1) << index;
    end
  end

  // Registered outputs with polarity applied; reset drives everything off
  always_ff @(posedge clk) begin
    if (rst) begin
      segment <= SEG_OFF;
      select  <= SEL_OFF;
    end else begin
      segment <= seg_lit ^ SEG_OFF;
      select  <= sel_lit ^ SEL_OFF;
    end
  end

endmodule

// File: doc/segment_scanner.md
SEGMENT_SCANNER -- requirements
Module: segment_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of multiplexed digits, legal 2..16.
REQ-002 SHALL have parameter PERIOD, default 1024: clocks per digit slot, multiple of 16, at least 32.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment or dp drives 0.
REQ-004 SHALL have parameter SEL_ACTIVE_LOW, default 0: 1 means the selected digit line drives 0.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port data  in  4*DIGITS  hex nibble per digit, digit i = data[4i+3:4i].
REQ-008 SHALL have port dp  in  DIGITS  decimal point per digit, 1 = lit.
REQ-009 SHALL have port blank  in  DIGITS  per-digit force-dark, 1 = dark.
REQ-010 SHALL have port lz_blank  in  1  leading-zero suppression enable.
REQ-011 SHALL have port brightness  in  4  on-time in sixteenths of a slot, 15 = full slot.
REQ-012 SHALL have port load  in  1  one-cycle strobe capturing data/dp/blank/lz_blank.
REQ-013 SHALL have port segment  out  8  {dp,g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-014 SHALL have port select  out  DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW.
REQ-015 SHALL have port frame_done  out  1  one-cycle pulse at end of each full scan.

Function
REQ-016 Slot counter SHALL count 0..PERIOD-1 then wrap to 0; digit index SHALL advance on counter = PERIOD-1, wrapping DIGITS-1 -> 0.
REQ-017 Frame end SHALL be index = DIGITS-1 with counter = PERIOD-1; frame_done SHALL be high for exactly that cycle.
REQ-018 load SHALL copy inputs to pending registers and set a pending flag; at frame end pending SHALL move to the active registers and the flag SHALL clear.
REQ-019 load coincident with frame end SHALL copy inputs straight to the active registers and leave the flag clear.
REQ-020 A second load before frame end SHALL overwrite pending; the last load wins.
REQ-021 Encoding (lit segments gfedcba, hex) SHALL be 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-022 brightness SHALL be sampled at counter = 0 of each slot; the digit is lit while counter < (brightness+1)*(PERIOD/16).
REQ-023 With active lz_blank = 1, digits from DIGITS-1 downward SHALL be dark while their nibble = 0 and dp = 0, up to the first non-zero or dp digit; digit 0 SHALL never be leading-zero blanked.
REQ-024 A dark digit (blank, leading zero, or off-window) SHALL drive all select lines inactive and all segment bits off.
REQ-025 segment and select SHALL be registered with 1-cycle latency: the output at cycle n+1 reflects counter/index/active registers at cycle n.
REQ-026 At most one select line SHALL be active in any cycle.

Reset
REQ-027 While rst is high at a clock edge, counter, index, active and pending registers, pending flag and frame_done SHALL clear to 0.
REQ-028 Under reset, segment SHALL read all-off (8'hFF if SEG_ACTIVE_LOW, else 8'h00) and select all-inactive.
REQ-029 Reset asserted mid-frame SHALL discard pending data; after release the scan SHALL restart at digit 0, counter 0.

Verification (DIGITS=4, PERIOD=32, both polarities active-low/active-high defaults)
REQ-030 Reset release, no load, brightness=15 -> digit 0 shows "0" (segment 8'hC0, select 4'b0001) from cycle 2 for 32 cycles; digits 1-3 also show "0"; frame_done every 128 cycles.
REQ-031 load data=16'h00A5, lz_blank=1, mid-frame -> display unchanged until frame_done, then digits 3 and 2 dark, digit 1 = A (8'h88), digit 0 = 5 (8'h92).
REQ-032 brightness=3 -> each slot lit for counter 0..7 and dark for 8..31; brightness=0 -> lit for counter 0..1 only.
REQ-033 load on the frame-end cycle with data=16'h1234 -> next frame shows 1234 with no one-frame delay; pending flag stays 0.
REQ-034 blank=4'b0100, dp=4'b0001 -> digit 2 always dark, digit 0 segment[7] lit (0); rst asserted mid-slot -> next edge all-off, scan restarts at digit 0.
